// File: rtl/dff_arb_pkg.sv
// Shared encodings for the dff_reg_arbiter slice: register commands and sequencer states.
package dff_arb_pkg;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_GRANT  = 2'b01,
    S_COMMIT = 2'b10
  } state_e;

endpackage

// File: rtl/dff_reg_arbiter_rr_pick.sv
// Combinational round-robin search: first set request bit starting at ptr_i, wrapping mod N.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [PW-1:0] win_o,
  output logic          vld_o
);

  // Walk from the farthest candidate back to ptr_i so the closest one is written last.
  always_comb begin
    win_o = '0;
    vld_o = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[(int'(ptr_i) + k) % N]) begin
        win_o = PW'((int'(ptr_i) + k) % N);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dff_reg_arbiter.sv
// Round-robin arbiter and IDLE/GRANT/COMMIT sequencer for one shared set/clear/load register.
// Optional macro DFF_ARB_LOCK_EN adds a per-requester lock input that holds the rr pointer.
module dff_reg_arbiter
  import dff_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic [N-1:0]         req,
  input  logic [2*N-1:0]       op,
  input  logic [N*WIDTH-1:0]   wdata,
`ifdef DFF_ARB_LOCK_EN
  input  logic [N-1:0]         lock,
`endif
  output logic [N-1:0]         gnt,
  output logic                 ack,
  output logic [WIDTH-1:0]     q,
  output logic                 busy
);

  localparam int PW = $clog2(N);

  state_e             state_q, state_d;
  logic [N-1:0]       gnt_q, gnt_d;
  logic               ack_q, ack_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      win_q, win_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   data_q, data_d;

  logic [PW-1:0]      pick_win;
  logic               pick_vld;
  logic               hold;

  rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .win_o (pick_win),
    .vld_o (pick_vld)
  );

`ifdef DFF_ARB_LOCK_EN
  assign hold = lock[win_q];
`else
  assign hold = 1'b0;
`endif

  function automatic logic [WIDTH-1:0] apply_op(input logic [1:0]       cmd,
                                                input logic [WIDTH-1:0] cur,
                                                input logic [WIDTH-1:0] din);
    case (cmd)
      OP_LOAD: return din;
      OP_SET:  return '1;
      OP_CLR:  return '0;
      default: return cur;
    endcase
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] w);
    return (int'(w) == N - 1) ? '0 : w + 1'b1;
  endfunction

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ack_d   = 1'b0;
    q_d     = q_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    op_d    = op_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        gnt_d = '0;
        if (pick_vld) begin
          win_d           = pick_win;
          gnt_d[pick_win] = 1'b1;
          state_d         = S_GRANT;
        end
      end
      // The winner must still be requesting at the capture edge; otherwise the grant is aborted.
      S_GRANT: begin
        if (req[win_q]) begin
          op_d    = op[2*int'(win_q) +: 2];
          data_d  = wdata[WIDTH*int'(win_q) +: WIDTH];
          state_d = S_COMMIT;
        end else begin
          gnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_COMMIT: begin
        q_d     = apply_op(op_q, q_q, data_q);
        ack_d   = 1'b1;
        gnt_d   = '0;
        ptr_d   = hold ? win_q : next_ptr(win_q);
        state_d = S_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      q_q     <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
      op_q    <= OP_NOP;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      q_q     <= q_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      op_q    <= op_d;
      data_q  <= data_d;
    end
  end

  assign gnt  = gnt_q;
  assign ack  = ack_q;
  assign q    = q_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Self-checking bench for dff_reg_arbiter (N=4, WIDTH=8): directed literal cases plus randomized traffic.
module tb_dff_reg_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           CLK = 1'b0;
  logic           Reset;
  logic [N-1:0]   req;
  logic [2*N-1:0] op;
  logic [N*W-1:0] wdata;
`ifdef DFF_ARB_LOCK_EN
  logic [N-1:0]   lock;
`endif
  logic [N-1:0]   gnt;
  logic           ack;
  logic [W-1:0]   q;
  logic           busy;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  dff_reg_arbiter #(.N(N), .WIDTH(W)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .req   (req),
    .op    (op),
    .wdata (wdata),
`ifdef DFF_ARB_LOCK_EN
    .lock  (lock),
`endif
    .gnt   (gnt),
    .ack   (ack),
    .q     (q),
    .busy  (busy)
  );

  // Transaction-level reference: phase 0 = no owner, 1 = owner granted, 2 = command captured.
  int           m_phase;
  int           m_win;
  int           m_ptr;
  int           m_last;
  logic [W-1:0] m_q;
  logic [W-1:0] m_data;
  logic [1:0]   m_op;
  logic         m_ack;

  task automatic m_reset();
    m_phase = 0; m_win = 0; m_ptr = 0; m_last = 0;
    m_q = '0; m_data = '0; m_op = 2'b00; m_ack = 1'b0;
  endtask

  task automatic m_step();
    m_ack = 1'b0;
    if (m_phase == 0) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (req[idx]) begin
          m_win = idx;
          m_phase = 1;
          break;
        end
      end
    end else if (m_phase == 1) begin
      if (req[m_win]) begin
        m_op   = op[2*m_win +: 2];
        m_data = wdata[W*m_win +: W];
        m_phase = 2;
      end else begin
        m_phase = 0;
      end
    end else begin
      if (m_op == 2'b01) m_q = m_data;
      else if (m_op == 2'b10) m_q = 8'hFF;
      else if (m_op == 2'b11) m_q = 8'h00;
      m_ack  = 1'b1;
      m_last = m_win;
      m_ptr  = (m_win + 1) % N;
`ifdef DFF_ARB_LOCK_EN
      if (lock[m_win]) m_ptr = m_win;
`endif
      m_phase = 0;
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge CLK or negedge Reset);
      if (!Reset) m_reset();
      else m_step();
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      check("model_gnt",  {28'd0, gnt}, (m_phase != 0) ? (32'd1 << m_win) : 32'd0);
      check("model_ack",  {31'd0, ack}, {31'd0, m_ack});
      check("model_q",    {24'd0, q},   {24'd0, m_q});
      check("model_busy", {31'd0, busy}, (m_phase != 0) ? 32'd1 : 32'd0);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic idle_all();
    req = '0; op = '0; wdata = '0;
`ifdef DFF_ARB_LOCK_EN
    lock = '0;
`endif
  endtask

  task automatic set_req(input int i, input logic [1:0] o, input logic [7:0] d);
    req[i] = 1'b1;
    op[2*i +: 2] = o;
    wdata[W*i +: W] = d;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    #2;
    Reset = 1'b1;
  endtask

  task automatic run_cmd(input int i, input logic [1:0] o, input logic [7:0] d,
                         input logic [7:0] exp_q, input string name);
    set_req(i, o, d);
    repeat (3) tick();
    check({name, "_ack"}, {31'd0, ack}, 32'd1);
    check({name, "_q"}, {24'd0, q}, {24'd0, exp_q});
    idle_all();
    tick();
  endtask

  initial begin
    Reset = 1'b1;
    idle_all();
    #1 Reset = 1'b0;
    repeat (2) tick();
    check("rst_q", {24'd0, q}, 32'd0);
    check("rst_gnt", {28'd0, gnt}, 32'd0);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    Reset = 1'b1;
    tick();

    // Reset asserted while in GRANT
    set_req(1, 2'b01, 8'h77);
    tick();
    check("t1_gnt", {28'd0, gnt}, 32'b0010);
    check("t1_busy", {31'd0, busy}, 32'd1);
    #1 Reset = 1'b0;
    #1;
    check("t1_async_q", {24'd0, q}, 32'd0);
    check("t1_async_gnt", {28'd0, gnt}, 32'd0);
    check("t1_async_ack", {31'd0, ack}, 32'd0);
    check("t1_async_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < N; i++) set_req(i, 2'b01, 8'h10 + 8'(i));
    Reset = 1'b1;
    tick();
    check("t1_first_gnt", {28'd0, gnt}, 32'b0001);
    tick();
    tick();
    check("t1_ack", {31'd0, ack}, 32'd1);
    check("t1_q", {24'd0, q}, 32'h10);
    idle_all();
    tick();

    // Single load from requester 2
    set_req(2, 2'b01, 8'hA5);
    tick();
    check("t2_gnt_a", {28'd0, gnt}, 32'b0100);
    check("t2_busy_a", {31'd0, busy}, 32'd1);
    tick();
    check("t2_gnt_b", {28'd0, gnt}, 32'b0100);
    check("t2_busy_b", {31'd0, busy}, 32'd1);
    check("t2_noack", {31'd0, ack}, 32'd0);
    tick();
    check("t2_ack", {31'd0, ack}, 32'd1);
    check("t2_q", {24'd0, q}, 32'hA5);
    check("t2_busy_c", {31'd0, busy}, 32'd0);
    check("t2_gnt_c", {28'd0, gnt}, 32'd0);
    idle_all();
    tick();
    check("t2_ack_drop", {31'd0, ack}, 32'd0);

    // All requesting continuously: rotation 0,1,2,3,0
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 2'b01, 8'(8'h11 * (i + 1)));
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t3_gnt", {28'd0, gnt}, 32'd1 << (k % 4));
      tick();
      tick();
      check("t3_ack", {31'd0, ack}, 32'd1);
      check("t3_q", {24'd0, q}, 32'(8'h11 * ((k % 4) + 1)));
    end
    idle_all();
    tick();

    // Set, clear, load, nop
    run_cmd(1, 2'b10, 8'h00, 8'hFF, "t4_set");
    run_cmd(1, 2'b11, 8'hFF, 8'h00, "t4_clr");
    run_cmd(1, 2'b01, 8'h3C, 8'h3C, "t4_load");
    run_cmd(1, 2'b00, 8'h99, 8'h3C, "t4_nop");

    // Abort: requester 3 drops before the capture edge
    do_reset();
    set_req(3, 2'b01, 8'hEE);
    tick();
    check("t5_gnt", {28'd0, gnt}, 32'b1000);
    req[3] = 1'b0;
    tick();
    check("t5_abort_gnt", {28'd0, gnt}, 32'd0);
    check("t5_abort_busy", {31'd0, busy}, 32'd0);
    check("t5_abort_ack", {31'd0, ack}, 32'd0);
    tick();
    check("t5_abort_ack2", {31'd0, ack}, 32'd0);
    check("t5_q", {24'd0, q}, 32'd0);
    for (int i = 0; i < N; i++) set_req(i, 2'b01, 8'h50 + 8'(i));
    tick();
    check("t5_next_gnt", {28'd0, gnt}, 32'b0001);
    tick();
    tick();
    check("t5_q_after", {24'd0, q}, 32'h50);
    idle_all();
    tick();

`ifdef DFF_ARB_LOCK_EN
    // Locked requester 0 wins twice, then rotation resumes
    do_reset();
    set_req(0, 2'b01, 8'hA0);
    set_req(1, 2'b01, 8'hB1);
    lock = 4'b0001;
    tick();
    check("t6_gnt_a", {28'd0, gnt}, 32'b0001);
    tick();
    tick();
    check("t6_q_a", {24'd0, q}, 32'hA0);
    lock = 4'b0000;
    tick();
    check("t6_gnt_b", {28'd0, gnt}, 32'b0001);
    tick();
    tick();
    check("t6_ack_b", {31'd0, ack}, 32'd1);
    tick();
    check("t6_gnt_c", {28'd0, gnt}, 32'b0010);
    tick();
    tick();
    check("t6_q_c", {24'd0, q}, 32'hB1);
    idle_all();
    tick();
`endif

    // Unconstrained inputs, including aborts and occasional async reset
    for (int c = 0; c < 1500; c++) begin
      tick();
      req   = 4'($urandom);
      op    = 8'($urandom);
      wdata = $urandom;
`ifdef DFF_ARB_LOCK_EN
      lock  = 4'($urandom);
`endif
      if ($urandom_range(0, 199) == 0) begin
        Reset = 1'b0;
        #1;
        Reset = 1'b1;
      end
    end
    idle_all();
    tick();

    // Well-behaved requesters: hold until ack, drop in the ack cycle, scramble op/wdata freely
    for (int c = 0; c < 1500; c++) begin
      tick();
      if (m_ack) req[m_last] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!req[i] && !(m_ack && m_last == i) && $urandom_range(0, 2) == 0) begin
          set_req(i, 2'($urandom), 8'($urandom));
        end else if ($urandom_range(0, 3) == 0) begin
          op[2*i +: 2] = 2'($urandom);
          wdata[W*i +: W] = 8'($urandom);
        end
      end
`ifdef DFF_ARB_LOCK_EN
      lock = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
`endif
    end
    idle_all();
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
